// File: rtl/int_pair_reducer_pkg.sv
// Shared types and arithmetic helpers for the int pair reduction stage.
// The saturating helpers are only called when INT_PAIR_REDUCER_SATURATE_EN is defined.
`timescale 1ns/1ps
package int_pair_pkg;

    typedef struct packed {
        logic signed [31:0] arg1;
        logic signed [31:0] arg2;
        logic               last;
    } pair_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EMIT
    } state_e;

    localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] SAT_MIN = 32'sh8000_0000;

    function automatic logic signed [31:0] pair_combine(input logic signed [31:0] a,
                                                        input logic signed [31:0] b);
        return a + b;
    endfunction

    // Signed overflow: operands agree in sign but the wrapped sum does not.
    function automatic logic add_ovf(input logic signed [31:0] a,
                                     input logic signed [31:0] b);
        logic signed [31:0] s;
        s = a + b;
        return (a[31] == b[31]) && (s[31] != a[31]);
    endfunction

    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        if (add_ovf(a, b)) begin
            return a[31] ? SAT_MIN : SAT_MAX;
        end
        return a + b;
    endfunction

endpackage

// File: rtl/int_pair_reducer_skid.sv
// Two-entry skid buffer for pair_t beats; in_ready is registered so there is no
// combinational path from in_valid to in_ready.
`timescale 1ns/1ps
module int_pair_skid
    import int_pair_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    output logic  in_ready,
    input  pair_t in_data,
    output logic  out_valid,
    input  logic  out_ready,
    output pair_t out_data
);

    pair_t      mem_q [2];
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       push;
    logic       pop;

    assign push      = in_valid && in_ready;
    assign pop       = out_ready && (count_q != 2'd0);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            // Accept again next cycle only while a free slot is guaranteed.
            in_ready <= (count_d <= 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: rtl/int_pair_reducer.sv
// Streaming pair reducer: sums arg1+arg2 over a frame and emits {sum, count, trunc}.
// Define INT_PAIR_REDUCER_SATURATE_EN for saturating arithmetic and the out_sat flag.
`timescale 1ns/1ps
module int_pair_reducer
    import int_pair_pkg::*;
#(
    parameter  int unsigned MAX_BEATS = 255,
    localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] in_arg1,
    input  logic signed [31:0] in_arg2,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] out_sum,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_trunc,
`ifdef INT_PAIR_REDUCER_SATURATE_EN
    output logic               out_sat,
`endif
    output logic               busy
);

    pair_t              in_pair;
    pair_t              head;
    logic               skid_valid;
    logic               pop;
    state_e             state;
    logic signed [31:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic signed [31:0] y;
    logic signed [31:0] base;
    logic signed [31:0] acc_new;
    logic [CNT_W-1:0]   cnt_new;
    logic               hit_max;
    logic               close;
    logic               trunc_new;
`ifdef INT_PAIR_REDUCER_SATURATE_EN
    logic               sat_q;
    logic               sat_new;
`endif

    assign in_pair = '{arg1: in_arg1, arg2: in_arg2, last: in_last};

    int_pair_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pair),
        .out_valid (skid_valid),
        .out_ready (pop),
        .out_data  (head)
    );

    // EMIT holds off pops; the skid keeps filling until it is full.
    assign pop  = skid_valid && (state != EMIT);
    assign busy = (state != IDLE) || skid_valid;

    always_comb begin
        base    = (state == IDLE) ? 32'sd0 : acc_q;
`ifdef INT_PAIR_REDUCER_SATURATE_EN
        y       = sat_add(head.arg1, head.arg2);
        acc_new = sat_add(base, y);
        sat_new = ((state == IDLE) ? 1'b0 : sat_q)
                  | add_ovf(head.arg1, head.arg2)
                  | add_ovf(base, y);
`else
        y       = pair_combine(head.arg1, head.arg2);
        acc_new = pair_combine(base, y);
`endif
        cnt_new   = (state == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
        hit_max   = (cnt_new == CNT_W'(MAX_BEATS));
        close     = head.last || hit_max;
        trunc_new = hit_max && !head.last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc_q     <= 32'sd0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= 32'sd0;
            out_count <= '0;
            out_trunc <= 1'b0;
`ifdef INT_PAIR_REDUCER_SATURATE_EN
            sat_q     <= 1'b0;
            out_sat   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (pop) begin
                        acc_q <= acc_new;
                        cnt_q <= cnt_new;
`ifdef INT_PAIR_REDUCER_SATURATE_EN
                        sat_q <= sat_new;
`endif
                        if (close) begin
                            state     <= EMIT;
                            out_valid <= 1'b1;
                            out_sum   <= acc_new;
                            out_count <= cnt_new;
                            out_trunc <= trunc_new;
`ifdef INT_PAIR_REDUCER_SATURATE_EN
                            out_sat   <= sat_new;
`endif
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_pair_reducer.sv
// Self-checking bench for int_pair_reducer (MAX_BEATS=4) with a scoreboard of frame results.
`timescale 1ns/1ps
module tb_int_pair_reducer;

    localparam int unsigned MB = 4;
    localparam int unsigned CW = $clog2(MB + 1);

    typedef struct packed {
        logic [31:0]   sum;
        logic [CW-1:0] cnt;
        logic          trunc;
        logic          sat;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_arg1;
    logic [31:0]   in_arg2;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_sum;
    logic [CW-1:0] out_count;
    logic          out_trunc;
    logic          out_sat;
    logic          busy;

    always #5 clk = ~clk;

    int_pair_reducer #(.MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_arg1   (in_arg1),
        .in_arg2   (in_arg2),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_trunc (out_trunc),
`ifdef INT_PAIR_REDUCER_SATURATE_EN
        .out_sat   (out_sat),
`endif
        .busy      (busy)
    );

`ifndef INT_PAIR_REDUCER_SATURATE_EN
    assign out_sat = 1'b0;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          viol     = 0;
    bit          hs_in;
    bit          prev_stall = 0;
    res_t        prev_out;
    res_t        exp_q[$];
    res_t        got_q[$];
    logic [31:0] m_acc;
    int          m_cnt = 0;
    bit          m_sat = 0;

`ifdef INT_PAIR_REDUCER_SATURATE_EN
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    function automatic logic [31:0] clamp(input longint s, inout bit o);
        if (s > SMAX) begin o = 1; return 32'h7FFF_FFFF; end
        if (s < SMIN) begin o = 1; return 32'h8000_0000; end
        return s[31:0];
    endfunction
`endif

    task automatic model_beat(input logic [31:0] a1, input logic [31:0] a2, input logic last);
        logic [31:0] y;
`ifdef INT_PAIR_REDUCER_SATURATE_EN
        bit o;
        o = 0;
        y = clamp(longint'($signed(a1)) + longint'($signed(a2)), o);
        if (m_cnt == 0) begin
            m_acc = y;
            m_sat = 0;
        end else begin
            m_acc = clamp(longint'($signed(m_acc)) + longint'($signed(y)), o);
        end
        m_sat = m_sat | o;
`else
        y = a1 + a2;
        m_acc = (m_cnt == 0) ? y : m_acc + y;
`endif
        m_cnt++;
        if (last || m_cnt == MB) begin
            exp_q.push_back('{sum: m_acc, cnt: CW'(m_cnt), trunc: !last, sat: m_sat});
            m_cnt = 0;
        end
    endtask

    // One clock: record handshakes seen before the edge, then advance to edge+1.
    task automatic cyc();
        res_t cur;
        cur = '{sum: out_sum, cnt: out_count, trunc: out_trunc, sat: out_sat};
        if (!rst && prev_stall && (out_valid !== 1'b1 || cur !== prev_out)) viol++;
        hs_in = !rst && in_valid && in_ready;
        if (!rst && out_valid && out_ready) got_q.push_back(cur);
        if (hs_in) model_beat(in_arg1, in_arg2, in_last);
        prev_stall = !rst && out_valid && !out_ready;
        prev_out   = cur;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a1, input logic [31:0] a2, input logic last);
        in_valid = 1'b1;
        in_arg1  = a1;
        in_arg2  = a2;
        in_last  = last;
        hs_in    = 1'b0;
        for (int i = 0; i < 100 && !hs_in; i++) cyc();
        n_checks++;
        if (!hs_in) begin
            n_fail++;
            $display("FAIL send_timeout got accepted=0 want accepted=1");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 300 && (busy || got_q.size() < exp_q.size()); i++) cyc();
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_arg1 = '0; in_arg2 = '0; in_last = 1'b0;
        cyc();
        cyc();
        n_checks++;
        if ({in_ready, out_valid, out_trunc, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got rdy/vld/trunc/busy=%b want 0000",
                     {in_ready, out_valid, out_trunc, busy});
        end
        n_checks++;
        if (out_sum !== 32'd0) begin
            n_fail++; $display("FAIL reset_sum got %h want 0", out_sum);
        end
        n_checks++;
        if (out_count !== '0) begin
            n_fail++; $display("FAIL reset_count got %0d want 0", out_count);
        end
        rst = 1'b0;
        m_cnt = 0; prev_stall = 0;
        clear_sb();
        cyc();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_after got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        res_t g;
        clear_sb();
        out_ready = 1'b1;
        send(32'd1, 32'd2, 1'b0);
        send(32'd3, 32'd4, 1'b0);
        send(32'hFFFF_FFFB, 32'd0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL latency_n1 got out_valid=%b want 0", out_valid);
        end
        cyc();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL latency_n2 got out_valid=%b want 1", out_valid);
        end
        drain();
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++; $display("FAIL single_count got %0d results want 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            n_checks++;
            if (g.sum !== 32'd5 || g.cnt !== CW'(3) || g.trunc !== 1'b0) begin
                n_fail++;
                $display("FAIL single_result got {%0d,%0d,%b} want {5,3,0}", g.sum, g.cnt, g.trunc);
            end
        end
    endtask

    task automatic test_trunc();
        res_t g;
        clear_sb();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(32'd1, 32'd1, i == 5);
        drain();
        n_checks++;
        if (got_q.size() != 2) begin
            n_fail++; $display("FAIL trunc_count got %0d results want 2", got_q.size());
        end else begin
            g = got_q.pop_front();
            n_checks++;
            if (g.sum !== 32'd8 || g.cnt !== CW'(4) || g.trunc !== 1'b1) begin
                n_fail++;
                $display("FAIL trunc_first got {%0d,%0d,%b} want {8,4,1}", g.sum, g.cnt, g.trunc);
            end
            g = got_q.pop_front();
            n_checks++;
            if (g.sum !== 32'd4 || g.cnt !== CW'(2) || g.trunc !== 1'b0) begin
                n_fail++;
                $display("FAIL trunc_second got {%0d,%0d,%b} want {4,2,0}", g.sum, g.cnt, g.trunc);
            end
        end
    endtask

    task automatic test_wrap();
        res_t g;
        res_t w;
`ifdef INT_PAIR_REDUCER_SATURATE_EN
        w = '{sum: 32'h7FFF_FFFF, cnt: CW'(1), trunc: 1'b0, sat: 1'b1};
`else
        w = '{sum: 32'h8000_0000, cnt: CW'(1), trunc: 1'b0, sat: 1'b0};
`endif
        clear_sb();
        send(32'h7FFF_FFFF, 32'd1, 1'b1);
        drain();
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++; $display("FAIL wrap_count got %0d results want 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            n_checks++;
            if (g !== w) begin
                n_fail++;
                $display("FAIL wrap_result got {%h,%0d,%b,%b} want {%h,%0d,%b,%b}",
                         g.sum, g.cnt, g.trunc, g.sat, w.sum, w.cnt, w.trunc, w.sat);
            end
        end
    endtask

    task automatic test_backpressure();
        int   k;
        int   accepted;
        res_t g;
        res_t e;
        clear_sb();
        viol = 0;
        out_ready = 1'b0;
        send(32'd1, 32'd1, 1'b1);
        k = 10;
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_arg1 = k; in_arg2 = 32'd0; in_last = 1'b0;
            cyc();
            if (hs_in) begin k++; accepted++; end
        end
        in_valid = 1'b0;
        n_checks++;
        if (accepted != 2) begin
            n_fail++; $display("FAIL bp_buffered got %0d beats want 2", accepted);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_ready_drop got in_ready=%b want 0", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd2) begin
            n_fail++; $display("FAIL bp_hold got vld=%b sum=%0d want vld=1 sum=2", out_valid, out_sum);
        end
        out_ready = 1'b1;
        send(k, 32'd0, 1'b1);
        drain();
        n_checks++;
        if (viol != 0) begin
            n_fail++; $display("FAIL bp_stable got %0d violations want 0", viol);
        end
        n_checks++;
        if (got_q.size() != 2 || exp_q.size() != 2) begin
            n_fail++;
            $display("FAIL bp_count got %0d results want 2 (model %0d)", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL bp_result got {%0d,%0d,%b} want {%0d,%0d,%b}",
                         g.sum, g.cnt, g.trunc, e.sum, e.cnt, e.trunc);
            end
        end
    endtask

    task automatic test_reset_mid();
        res_t g;
        clear_sb();
        out_ready = 1'b1;
        send(32'd5, 32'd5, 1'b0);
        send(32'd6, 32'd6, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_cnt = 0; prev_stall = 0;
        clear_sb();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_flush got busy=%b vld=%b want 0 0", busy, out_valid);
        end
        cyc();
        send(32'd7, 32'd0, 1'b1);
        drain();
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++; $display("FAIL rstmid_count got %0d results want 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            n_checks++;
            if (g.sum !== 32'd7 || g.cnt !== CW'(1) || g.trunc !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_result got {%0d,%0d,%b} want {7,1,0}", g.sum, g.cnt, g.trunc);
            end
        end
    endtask

    task automatic test_random();
        int   budget;
        int   len;
        int   bad;
        res_t g;
        res_t e;
        clear_sb();
        viol = 0;
        budget = 0;
        bad = 0;
        for (int f = 0; f < 1000 && budget < 60000; f++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                in_arg1 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 200);
                in_arg2 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 200);
                in_last = (b == len - 1);
                hs_in = 1'b0;
                while (!hs_in && budget < 60000) begin
                    in_valid  = ($urandom_range(0, 3) != 0);
                    out_ready = ($urandom_range(0, 2) != 0);
                    cyc();
                    budget++;
                end
            end
        end
        drain();
        n_checks++;
        if (budget >= 60000) begin
            n_fail++; $display("FAIL rand_budget got %0d cycles want <60000", budget);
        end
        n_checks++;
        if (viol != 0) begin
            n_fail++; $display("FAIL rand_protocol got %0d violations want 0", viol);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count got %0d results want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL rand_result got {%h,%0d,%b,%b} want {%h,%0d,%b,%b}",
                             g.sum, g.cnt, g.trunc, g.sat, e.sum, e.cnt, e.trunc, e.sat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_trunc();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800us;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
